book_update_scheduler: RTL and testbench
========================================

BOOK_UPDATE_SCHEDULER -- requirements
Module: book_update_scheduler

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, meaning pending-message buffer depth (power of two, >=2).
REQ-002 SHALL have parameter ID_W, default 32, meaning security ID width.
REQ-003 SHALL have port clk  input  1  the single clock; all state is on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have ports in_valid input 1 / in_ready output 1: the parser-side message handshake.
REQ-006 SHALL have parser-side message inputs in_num_orders (8), in_quantity (16), in_price (64), in_action (2), in_entry_type (2) and in_security_id (ID_W).
REQ-007 SHALL have inputs cfg_security_id (ID_W), the instrument to track, and cfg_enable (1), the issue enable.
REQ-008 SHALL have outputs ob_message_ready (1) and ob_enable (1), the order-book strobes.
REQ-009 SHALL have order-book field outputs ob_num_orders (8), ob_quantity (16), ob_price (64), ob_action (2), ob_entry_type (2) and ob_security_id (ID_W).
REQ-010 SHALL have outputs book_updated (1), a one-cycle notify to downstream, and busy (1), high when the FSM is not in IDLE or the FIFO is non-empty.

Function
REQ-011 SHALL buffer messages in a FIFO_DEPTH FIFO; in_ready = !full; a push occurs when in_valid && in_ready.
REQ-012 SHALL hold in_ready low when full, even if a pop occurs in the same cycle.
REQ-013 SHALL keep the FIFO contents unchanged while in_valid is high and in_ready is low.
REQ-014 SHALL implement FSM states IDLE, ISSUE, SETTLE, NOTIFY.
REQ-015 IDLE: if the FIFO is non-empty and cfg_enable=1, SHALL pop the head into holding registers.
REQ-016 On a popped message, SHALL go to ISSUE if security_id==cfg_security_id, action<=2 and entry_type<=1.
REQ-017 On a popped message that fails REQ-016, SHALL discard it and remain in IDLE.
REQ-018 ISSUE: SHALL assert ob_message_ready=1 and ob_enable=1 for exactly one cycle with the held fields, then go to SETTLE.
REQ-019 SETTLE: SHALL wait one cycle for the book to register the update, strobes low, then go to NOTIFY.
REQ-020 NOTIFY: SHALL pulse book_updated for one cycle, then go to IDLE.
REQ-021 ob_* field outputs SHALL be stable from ISSUE through NOTIFY and SHALL hold their last value otherwise.
REQ-022 Latency: a message pushed at cycle t with an empty FIFO and idle FSM SHALL give ISSUE at t+2 and book_updated at t+4.
REQ-023 Sustained throughput SHALL be one issued message per 4 cycles; discarded messages SHALL cost 1 cycle each.
REQ-024 cfg_enable deassertion SHALL let an in-flight message complete ISSUE→NOTIFY; further pops SHALL then be blocked and the FIFO retained.
REQ-025 cfg_security_id SHALL be sampled only at pop; a change mid-flight SHALL not affect the in-flight message.
REQ-026 Pointers SHALL wrap modulo FIFO_DEPTH; occupancy SHALL use a log2(FIFO_DEPTH)+1-bit counter.

Reset
REQ-027 reset SHALL set state=IDLE, empty the FIFO, and zero the holding registers.
REQ-028 During reset: in_ready=0, ob_message_ready=0, ob_enable=0, book_updated=0, busy=0, all ob_* fields=0.
REQ-029 reset asserted in any state SHALL abort without emitting any further strobe or book_updated.
REQ-030 in_ready SHALL rise in the first cycle after reset deasserts.

Configuration
REQ-031 With macro BOOK_SCHED_STATS_EN defined, SHALL add outputs issued_count (32) and dropped_count (32); both saturate and reset to 0.
REQ-032 issued_count SHALL increment at ISSUE; dropped_count SHALL increment on each discard.
REQ-033 Without BOOK_SCHED_STATS_EN, the count ports and counters SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-034 Package mdp_pkg SHALL hold action encodings (NEW=0, CHANGE=1, DELETE=2), entry types (BID=0, ASK=1), the sched_state_t enum, and the message struct typedef.
REQ-035 The FIFO SHALL be a sub-module named sched_fifo (push/pop/full/empty, parameter DEPTH, struct payload).

Verification
REQ-036 Single match: cfg_security_id=0x1234, push {NEW,BID,price 9,qty 5,orders 1,id 0x1234} at t → ob strobes at t+2 only, book_updated at t+4, busy low at t+5.
REQ-037 Filter: push ids 0x1111 then 0x1234 back-to-back → only 0x1234 is issued; with stats, dropped_count=1 and issued_count=1.
REQ-038 Full: hold in_valid with cfg_enable=0 → exactly 4 accepted and in_ready=0; set cfg_enable=1 → 4 issues in order, spaced 4 cycles apart.
REQ-039 Illegal fields: action=3 or entry_type=2 with a matching id → no strobe, and the message is dropped.
REQ-040 Reset in SETTLE: assert reset 1 cycle → no book_updated, FIFO empty, in_ready=1 on the next cycle.
REQ-041 Enable drop mid-flight: cfg_enable→0 during ISSUE → NOTIFY completes and the 2 queued messages remain held until re-enable.

Source files
------------

// File: rtl/mdp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mdp_pkg
// Description : Shared definitions for the book update scheduler: action and
//               entry-type encodings, scheduler FSM states, the order-book
//               message body, and a field legality helper.
// Revision    : 1.0 - initial release
// ============================================================================
package mdp_pkg;

    // Action encodings
    localparam logic [1:0] c_ACT_NEW    = 2'd0;
    localparam logic [1:0] c_ACT_CHANGE = 2'd1;
    localparam logic [1:0] c_ACT_DELETE = 2'd2;

    // Entry-type encodings
    localparam logic [1:0] c_ENTRY_BID  = 2'd0;
    localparam logic [1:0] c_ENTRY_ASK  = 2'd1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_SETTLE = 2'd2,
        ST_NOTIFY = 2'd3
    } sched_state_t;

    // Message body. The security ID lives beside it because its width is a
    // module parameter and a package type cannot depend on it.
    typedef struct packed {
        logic [7:0]  num_orders;
        logic [15:0] quantity;
        logic [63:0] price;
        logic [1:0]  action;
        logic [1:0]  entry_type;
    } mdp_msg_t;

    function automatic logic msg_fields_legal(input logic [1:0] action,
                                              input logic [1:0] entry_type);
        return (action <= c_ACT_DELETE) && (entry_type <= c_ENTRY_ASK);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sched_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sched_fifo
// Description : Synchronous FIFO holding pending scheduler entries. The head
//               entry is presented on pop_data whenever empty is low.
// Ports       : clk, reset (sync, active-high)
//               push, push_data      - write side (ignored when full)
//               pop, pop_data        - read side  (ignored when empty)
//               full, empty          - occupancy flags
// Parameters  : DEPTH (power of two, >= 2), PAYLOAD_T (entry type)
// Revision    : 1.0 - initial release
// ============================================================================
module sched_fifo import mdp_pkg::*; #(
    parameter int  DEPTH     = 4,
    parameter type PAYLOAD_T = mdp_msg_t
) (
    input  logic     clk,
    input  logic     reset,
    input  logic     push,
    input  PAYLOAD_T push_data,
    input  logic     pop,
    output PAYLOAD_T pop_data,
    output logic     full,
    output logic     empty
);

    localparam int             AW           = $clog2(DEPTH);
    localparam logic [AW:0]    c_FULL_COUNT = (AW+1)'(DEPTH);

    PAYLOAD_T          mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [AW:0]       count_q,  count_d;
    logic              w_push;
    logic              w_pop;

    assign full     = (count_q == c_FULL_COUNT);
    assign empty    = (count_q == '0);
    assign w_push   = push && !full;
    assign w_pop    = pop && !empty;
    assign pop_data = mem_q[rd_ptr_q];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (w_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (w_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({w_push, w_pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: the occupancy counter defines what is valid.
    always_ff @(posedge clk) begin
        if (w_push) mem_q[wr_ptr_q] <= push_data;
    end

endmodule
`default_nettype wire

// File: rtl/book_update_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : book_update_scheduler
// Description : Buffers parser messages, filters them against the tracked
//               instrument and legal field ranges, and sequences each match
//               to the order book: ISSUE (strobes) -> SETTLE -> NOTIFY
//               (book_updated pulse). Non-matching messages are dropped at
//               one per cycle.
// Ports       : clk, reset (sync, active-high)
//               in_valid/in_ready + in_* fields    - parser message input
//               cfg_security_id, cfg_enable        - filter / issue enable
//               ob_message_ready, ob_enable, ob_*  - order-book interface
//               book_updated, busy                 - status
//               issued_count, dropped_count        - only with
//                                                    BOOK_SCHED_STATS_EN
// Config      : define BOOK_SCHED_STATS_EN to add saturating 32-bit
//               issued/dropped counters.
// Revision    : 1.0 - initial release
// ============================================================================
module book_update_scheduler import mdp_pkg::*; #(
    parameter int FIFO_DEPTH = 4,
    parameter int ID_W       = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [7:0]      in_num_orders,
    input  logic [15:0]     in_quantity,
    input  logic [63:0]     in_price,
    input  logic [1:0]      in_action,
    input  logic [1:0]      in_entry_type,
    input  logic [ID_W-1:0] in_security_id,
    input  logic [ID_W-1:0] cfg_security_id,
    input  logic            cfg_enable,
    output logic            ob_message_ready,
    output logic            ob_enable,
    output logic [7:0]      ob_num_orders,
    output logic [15:0]     ob_quantity,
    output logic [63:0]     ob_price,
    output logic [1:0]      ob_action,
    output logic [1:0]      ob_entry_type,
    output logic [ID_W-1:0] ob_security_id,
    output logic            book_updated,
    output logic            busy
`ifdef BOOK_SCHED_STATS_EN
    ,
    output logic [31:0]     issued_count,
    output logic [31:0]     dropped_count
`endif
);

    typedef struct packed {
        logic [ID_W-1:0] security_id;
        mdp_msg_t        msg;
    } sched_entry_t;

    sched_state_t  state_q,  state_d;
    sched_entry_t  hold_q,   hold_d;
    logic          strobe_q, strobe_d;
    logic          notify_q, notify_d;

    sched_entry_t  w_in_entry;
    sched_entry_t  w_head;
    logic          w_fifo_full;
    logic          w_fifo_empty;
    logic          w_push;
    logic          w_pop;
    logic          w_head_match;

    assign w_in_entry.security_id    = in_security_id;
    assign w_in_entry.msg.num_orders = in_num_orders;
    assign w_in_entry.msg.quantity   = in_quantity;
    assign w_in_entry.msg.price      = in_price;
    assign w_in_entry.msg.action     = in_action;
    assign w_in_entry.msg.entry_type = in_entry_type;

    // in_ready depends only on full, never on a same-cycle pop.
    assign in_ready = !reset && !w_fifo_full;
    assign w_push   = in_valid && in_ready;

    sched_fifo #(
        .DEPTH     (FIFO_DEPTH),
        .PAYLOAD_T (sched_entry_t)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (w_push),
        .push_data (w_in_entry),
        .pop       (w_pop),
        .pop_data  (w_head),
        .full      (w_fifo_full),
        .empty     (w_fifo_empty)
    );

    // cfg_security_id is only consulted here, at pop time.
    assign w_head_match = (w_head.security_id == cfg_security_id) &&
                          msg_fields_legal(w_head.msg.action, w_head.msg.entry_type);

    always_comb begin
        state_d  = state_q;
        hold_d   = hold_q;
        strobe_d = 1'b0;
        notify_d = 1'b0;
        w_pop    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!w_fifo_empty && cfg_enable) begin
                    w_pop = 1'b1;
                    // Discards leave the holding registers (and ob_*) untouched.
                    if (w_head_match) begin
                        hold_d   = w_head;
                        state_d  = ST_ISSUE;
                        strobe_d = 1'b1;
                    end
                end
            end
            ST_ISSUE:  state_d = ST_SETTLE;
            ST_SETTLE: begin
                state_d  = ST_NOTIFY;
                notify_d = 1'b1;
            end
            ST_NOTIFY: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            hold_q   <= '0;
            strobe_q <= 1'b0;
            notify_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            hold_q   <= hold_d;
            strobe_q <= strobe_d;
            notify_q <= notify_d;
        end
    end

    // Outputs are forced low while reset is asserted so that an abort in any
    // state emits nothing further, even in the reset cycle itself.
    assign ob_message_ready = !reset && strobe_q;
    assign ob_enable        = !reset && strobe_q;
    assign book_updated     = !reset && notify_q;
    assign busy             = !reset && ((state_q != ST_IDLE) || !w_fifo_empty);

    assign ob_num_orders  = reset ? '0 : hold_q.msg.num_orders;
    assign ob_quantity    = reset ? '0 : hold_q.msg.quantity;
    assign ob_price       = reset ? '0 : hold_q.msg.price;
    assign ob_action      = reset ? '0 : hold_q.msg.action;
    assign ob_entry_type  = reset ? '0 : hold_q.msg.entry_type;
    assign ob_security_id = reset ? '0 : hold_q.security_id;

`ifdef BOOK_SCHED_STATS_EN
    logic [31:0] issued_q,  issued_d;
    logic [31:0] dropped_q, dropped_d;
    logic        w_drop;

    assign w_drop = w_pop && !w_head_match;

    always_comb begin
        issued_d  = issued_q;
        dropped_d = dropped_q;
        if ((state_q == ST_ISSUE) && (issued_q != '1)) issued_d  = issued_q + 32'd1;
        if (w_drop && (dropped_q != '1))               dropped_d = dropped_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            issued_q  <= '0;
            dropped_q <= '0;
        end else begin
            issued_q  <= issued_d;
            dropped_q <= dropped_d;
        end
    end

    assign issued_count  = issued_q;
    assign dropped_count = dropped_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_book_update_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_book_update_scheduler
// Description : Scoreboard bench. Stimulus pushes the expected order-book
//               transaction (fields, strobe cycle, notify cycle) into a
//               queue; a negedge monitor pops and compares whenever the DUT
//               strobes or pulses book_updated.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_book_update_scheduler;

    localparam logic [1:0] NEW = 2'd0, CHG = 2'd1, DEL = 2'd2;
    localparam logic [1:0] BID = 2'd0, ASK = 2'd1;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_num_orders;
    logic [15:0] in_quantity;
    logic [63:0] in_price;
    logic [1:0]  in_action;
    logic [1:0]  in_entry_type;
    logic [31:0] in_security_id;
    logic [31:0] cfg_security_id;
    logic        cfg_enable;
    logic        ob_message_ready;
    logic        ob_enable;
    logic [7:0]  ob_num_orders;
    logic [15:0] ob_quantity;
    logic [63:0] ob_price;
    logic [1:0]  ob_action;
    logic [1:0]  ob_entry_type;
    logic [31:0] ob_security_id;
    logic        book_updated;
    logic        busy;

    book_update_scheduler #(.FIFO_DEPTH(4), .ID_W(32)) dut (
        .clk              (clk),
        .reset            (reset),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .in_num_orders    (in_num_orders),
        .in_quantity      (in_quantity),
        .in_price         (in_price),
        .in_action        (in_action),
        .in_entry_type    (in_entry_type),
        .in_security_id   (in_security_id),
        .cfg_security_id  (cfg_security_id),
        .cfg_enable       (cfg_enable),
        .ob_message_ready (ob_message_ready),
        .ob_enable        (ob_enable),
        .ob_num_orders    (ob_num_orders),
        .ob_quantity      (ob_quantity),
        .ob_price         (ob_price),
        .ob_action        (ob_action),
        .ob_entry_type    (ob_entry_type),
        .ob_security_id   (ob_security_id),
        .book_updated     (book_updated),
        .busy             (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] id;
        logic [63:0] price;
        logic [15:0] qty;
        logic [7:0]  n;
        logic [1:0]  act;
        logic [1:0]  et;
        int          scyc;
        int          ncyc;
    } exp_t;

    exp_t exp_q[$];
    int   nq[$];
    exp_t last_e;
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic exp_add(input logic [31:0] id, input logic [1:0] act, input logic [1:0] et,
                           input logic [63:0] pr, input logic [15:0] q, input logic [7:0] n,
                           input int scyc, input int ncyc);
        exp_t e;
        e.id = id; e.act = act; e.et = et; e.price = pr; e.qty = q; e.n = n;
        e.scyc = scyc; e.ncyc = ncyc;
        exp_q.push_back(e);
    endtask

    // Called at posedge+1; returns at posedge+1 with pcyc = cycle of the push edge.
    task automatic drive_push(input logic [31:0] id, input logic [1:0] act, input logic [1:0] et,
                              input logic [63:0] pr, input logic [15:0] q, input logic [7:0] n,
                              output int pcyc);
        in_valid = 1'b1; in_security_id = id; in_action = act; in_entry_type = et;
        in_price = pr; in_quantity = q; in_num_orders = n;
        @(posedge clk); #1;
        pcyc = cyc;
        in_valid = 1'b0;
    endtask

    task automatic wait_neg(input int n);
        do @(negedge clk); while (cyc < n);
    endtask

    task automatic align();
        @(posedge clk); #1;
    endtask

    // Monitor: checks every strobe and every book_updated against the scoreboard.
    always @(negedge clk) begin
        if (ob_message_ready) begin
            chk("strobe_expected", exp_q.size() > 0, 1'b1);
            if (exp_q.size() > 0) begin
                exp_t e;
                e = exp_q.pop_front();
                chk("strobe_cycle", cyc, e.scyc);
                chk("ob_enable", ob_enable, 1'b1);
                chk("ob_security_id", ob_security_id, e.id);
                chk("ob_price", ob_price, e.price);
                chk("ob_act_et_n_qty", {ob_action, ob_entry_type, ob_num_orders, ob_quantity},
                    {e.act, e.et, e.n, e.qty});
                if (e.ncyc >= 0) nq.push_back(e.ncyc);
                last_e = e;
            end
        end else begin
            chk("ob_enable_idle", ob_enable, 1'b0);
        end
        if (book_updated) begin
            chk("notify_expected", nq.size() > 0, 1'b1);
            if (nq.size() > 0) begin
                int n;
                n = nq.pop_front();
                chk("notify_cycle", cyc, n);
                chk("notify_ob_id", ob_security_id, last_e.id);
                chk("notify_ob_price", ob_price, last_e.price);
            end
        end
    end

    initial begin
        int p, p2, e0, r, k;
        logic acc;

        reset = 1'b1; in_valid = 1'b0; in_security_id = '0; in_action = '0;
        in_entry_type = '0; in_price = '0; in_quantity = '0; in_num_orders = '0;
        cfg_security_id = 32'h1234; cfg_enable = 1'b1;

        // ---- reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_ob_msg_ready", ob_message_ready, 1'b0);
        chk("rst_book_updated", book_updated, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_ob_fields", {ob_price, ob_security_id, ob_quantity}, '0);
        align();
        reset = 1'b0;
        @(negedge clk);
        chk("in_ready_after_reset", in_ready, 1'b1);
        chk("busy_after_reset", busy, 1'b0);
        align();

        // ---- single match: strobe t+1.. i.e. ISSUE at push+1 edge, notify +3, idle +4
        drive_push(32'h1234, NEW, BID, 64'd9, 16'd5, 8'd1, p);
        exp_add(32'h1234, NEW, BID, 64'd9, 16'd5, 8'd1, p + 1, p + 3);
        wait_neg(p + 3);
        chk("single_busy_notify", busy, 1'b1);
        wait_neg(p + 4);
        chk("single_busy_done", busy, 1'b0);
        chk("single_ob_hold", ob_quantity, 16'd5);
        align();

        // ---- filter: first id dropped in one cycle, second issued right after
        drive_push(32'h1111, NEW, BID, 64'd1, 16'd1, 8'd1, p);
        drive_push(32'h1234, CHG, ASK, 64'd77, 16'd8, 8'd2, p2);
        exp_add(32'h1234, CHG, ASK, 64'd77, 16'd8, 8'd2, p + 2, p + 4);
        wait_neg(p2 + 5);
        chk("filter_busy_done", busy, 1'b0);
        align();

        // ---- illegal fields with matching id: dropped, ob_* keep last value
        drive_push(32'h1234, 2'd3, BID, 64'd500, 16'd3, 8'd3, p);
        drive_push(32'h1234, NEW, 2'd2, 64'd600, 16'd4, 8'd4, p);
        wait_neg(p + 4);
        chk("illegal_busy_done", busy, 1'b0);
        chk("illegal_ob_price_held", ob_price, 64'd77);
        align();
        drive_push(32'h1234, DEL, BID, 64'd50, 16'd6, 8'd7, p);
        exp_add(32'h1234, DEL, BID, 64'd50, 16'd6, 8'd7, p + 1, p + 3);
        wait_neg(p + 5);
        align();

        // ---- full: enable low, hold in_valid; exactly 4 accepted
        cfg_enable = 1'b0;
        k = 0;
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1; in_security_id = 32'h1234;
            in_action = 2'(k % 3); in_entry_type = 2'(k % 2);
            in_price = 64'd1000 + 64'(k); in_quantity = 16'd10 + 16'(k); in_num_orders = 8'(k + 1);
            @(negedge clk);
            acc = in_ready;
            chk($sformatf("full_in_ready_%0d", i), in_ready, (i < 4) ? 1'b1 : 1'b0);
            align();
            if (acc) k++;
        end
        in_valid = 1'b0;
        chk("full_accepted", k, 4);
        @(negedge clk);
        chk("full_in_ready_low", in_ready, 1'b0);
        align();
        e0 = cyc;
        for (int j = 0; j < 4; j++)
            exp_add(32'h1234, 2'(j % 3), 2'(j % 2), 64'd1000 + 64'(j), 16'd10 + 16'(j),
                    8'(j + 1), e0 + 1 + 4 * j, e0 + 3 + 4 * j);
        cfg_enable = 1'b1;
        wait_neg(e0 + 17);
        chk("full_drain_busy", busy, 1'b0);
        align();

        // ---- reset during SETTLE: no notify, queued message flushed
        drive_push(32'h1234, NEW, ASK, 64'd321, 16'd2, 8'd9, p);
        exp_add(32'h1234, NEW, ASK, 64'd321, 16'd2, 8'd9, p + 1, -1);
        drive_push(32'h1234, CHG, BID, 64'd654, 16'd3, 8'd8, p2);
        align();
        reset = 1'b1;
        @(negedge clk);
        chk("rs_during_in_ready", in_ready, 1'b0);
        chk("rs_during_busy", busy, 1'b0);
        chk("rs_during_ob_price", ob_price, 64'd0);
        align();
        reset = 1'b0;
        @(negedge clk);
        chk("rs_after_in_ready", in_ready, 1'b1);
        chk("rs_after_busy", busy, 1'b0);
        chk("rs_after_book_updated", book_updated, 1'b0);
        chk("rs_after_ob_id", ob_security_id, 32'h0);
        repeat (8) @(negedge clk);
        chk("rs_fifo_flushed", busy, 1'b0);
        align();

        // ---- enable drop during ISSUE; cfg id changes mid-flight too
        drive_push(32'h1234, NEW, BID, 64'd11, 16'd21, 8'd31, p);
        exp_add(32'h1234, NEW, BID, 64'd11, 16'd21, 8'd31, p + 1, p + 3);
        drive_push(32'h1234, CHG, ASK, 64'd12, 16'd22, 8'd32, p2);
        cfg_enable = 1'b0;
        cfg_security_id = 32'h9999;
        drive_push(32'h1234, DEL, ASK, 64'd13, 16'd23, 8'd33, p2);
        wait_neg(p + 12);
        chk("hold_busy", busy, 1'b1);
        chk("hold_in_ready", in_ready, 1'b1);
        chk("hold_ob_id", ob_security_id, 32'h1234);
        align();
        r = cyc;
        cfg_security_id = 32'h1234;
        cfg_enable = 1'b1;
        exp_add(32'h1234, CHG, ASK, 64'd12, 16'd22, 8'd32, r + 1, r + 3);
        exp_add(32'h1234, DEL, ASK, 64'd13, 16'd23, 8'd33, r + 5, r + 7);
        wait_neg(r + 9);
        chk("reenable_busy_done", busy, 1'b0);

        chk("pending_strobes", exp_q.size(), 0);
        chk("pending_notifies", nq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
